uart_recv: RTL and testbench

//  8N1 UART receiver, LSB first, idle-high line. Samples uart_rxd asynchronously
//  to sys_clk and recovers each byte. Presents the byte with a one-cycle done

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 43 ++++
 rtl/uart_recv.sv | 134 +++++++++++++
 tb/tb_uart_recv.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module     : uart_pkg
// Description: Shared UART constants and FSM state encodings (RX and TX).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [15:0] BPS_CNT_DEF   = 16'd434;   // 50 MHz / 115200
    localparam logic [3:0]  START_IDX     = 4'd0;
    localparam logic [3:0]  LAST_DATA_IDX = 4'd8;
    localparam logic [3:0]  STOP_IDX      = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module     : uart_rx_sync
// Description: Two-flop synchroniser for uart_rxd plus a delay flop for
//              falling-edge (start bit) detection.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic uart_rxd,
    output logic rxd_s,
    output logic start_fall
);

    logic       meta_q;
    logic       sync_q;
    logic       dly_q;
    logic [2:0] fill_q;

    // fill_q marks when all three stages hold real pin samples, so a line
    // held low through reset release never looks like a falling edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
            fill_q <= 3'b000;
        end else begin
            meta_q <= uart_rxd;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            fill_q <= {fill_q[1:0], 1'b1};
        end
    end

    assign rxd_s      = sync_q;
    assign start_fall = fill_q[2] & ~sync_q & dly_q;

endmodule

`default_nettype wire

// File: rtl/uart_recv.sv
// ============================================================================
// Module     : uart_recv
// Description: 8N1 UART receiver, LSB first; mid-bit sampling, done pulse on
//              good stop bit, frame_err pulse on low stop bit.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_recv
    import uart_pkg::*;
#(
    parameter logic [15:0] BPS_CNT = BPS_CNT_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [15:0] LAST_CNT = BPS_CNT - 16'd1;
    localparam logic [15:0] SMP_CNT  = BPS_CNT / 16'd2;

    logic        w_rxd_s;
    logic        w_start_fall;
    logic        w_wrap;
    logic        w_smp;
    logic [2:0]  w_bit_pos;

    uart_state_e state_q,   state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q,   shift_d;
    logic [7:0]  data_q,    data_d;
    logic        done_q,    done_d;
    logic        ferr_q,    ferr_d;

    uart_rx_sync u_sync (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_rxd   (uart_rxd),
        .rxd_s      (w_rxd_s),
        .start_fall (w_start_fall)
    );

    assign w_wrap    = (clk_cnt_q == LAST_CNT);
    assign w_smp     = (clk_cnt_q == SMP_CNT);
    assign w_bit_pos = bit_idx_q[2:0] - 3'd1;   // data bit 1..8 -> shift bit 0..7

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= 16'd0;
            bit_idx_q <= START_IDX;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        if (state_q != S_IDLE) begin
            clk_cnt_d = w_wrap ? 16'd0 : clk_cnt_q + 16'd1;
            if (w_wrap) begin
                bit_idx_d = bit_idx_q + 4'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_start_fall) begin
                    state_d   = S_START;
                    clk_cnt_d = 16'd0;
                    bit_idx_d = START_IDX;
                end
            end
            S_START: begin
                if (w_smp && w_rxd_s) begin
                    state_d = S_IDLE;
                end else if (w_wrap) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_smp) begin
                    shift_d[w_bit_pos] = w_rxd_s;
                end
                if (w_wrap && (bit_idx_q == LAST_DATA_IDX)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop gives half a bit to catch a back-to-back start.
                if (w_smp) begin
                    state_d = S_IDLE;
                    if (w_rxd_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign uart_data = data_q;
    assign uart_done = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_recv.sv
// ============================================================================
// Module     : tb_uart_recv
// Description: Directed self-checking bench for uart_recv with BPS_CNT=16.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_recv;

    localparam int BIT_CYC = 16;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       uart_rxd;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    logic       rx_busy;

    int         n_assert;
    int         n_fail;
    int         done_cnt;
    int         ferr_cnt;
    int         both_cnt;
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;
    int         done_base;

    uart_recv #(.BPS_CNT(16'd16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .uart_data (uart_data),
        .uart_done (uart_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (uart_done) begin
            done_cnt++;
            rx_q.push_back(uart_data);
        end
        if (frame_err) ferr_cnt++;
        if (uart_done && frame_err) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Line is left at the stop-bit level when the task returns.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int cyc);
        uart_rxd = 1'b0;
        tick(cyc);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(cyc);
        end
        uart_rxd = stop;
        tick(cyc);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        done_cnt = 0; ferr_cnt = 0; both_cnt = 0;
        uart_rxd  = 1'b1;
        sys_rst_n = 1'b0;
        tick(4);
        check_eq("rst_data", {24'd0, uart_data}, 32'h00);
        check_eq("rst_done", {31'd0, uart_done}, 32'd0);
        check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("rst_busy", {31'd0, rx_busy}, 32'd0);
        sys_rst_n = 1'b1;
        tick(6);

        // 1: good frame 0x55
        send_byte(8'h55, 1'b1, BIT_CYC);
        tick(8);
        check_eq("t1_done_cnt", done_cnt, 1);
        rx_byte = rx_q[0];
        check_eq("t1_pulse_data", {24'd0, rx_byte}, 32'h55);
        check_eq("t1_data", {24'd0, uart_data}, 32'h55);
        check_eq("t1_ferr_cnt", ferr_cnt, 0);
        check_eq("t1_busy", {31'd0, rx_busy}, 32'd0);

        // 2: 4-cycle low glitch
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        tick(2);
        check_eq("t2_busy_hi", {31'd0, rx_busy}, 32'd1);
        tick(20);
        check_eq("t2_busy_lo", {31'd0, rx_busy}, 32'd0);
        check_eq("t2_done_cnt", done_cnt, 1);
        check_eq("t2_ferr_cnt", ferr_cnt, 0);

        // 3: bad stop bit, line then held low
        send_byte(8'hA3, 1'b0, BIT_CYC);
        tick(40);
        check_eq("t3_ferr_cnt", ferr_cnt, 1);
        check_eq("t3_done_cnt", done_cnt, 1);
        check_eq("t3_data", {24'd0, uart_data}, 32'h55);
        check_eq("t3_busy_low_line", {31'd0, rx_busy}, 32'd0);
        uart_rxd = 1'b1;
        tick(20);
        check_eq("t3_busy_after_rise", {31'd0, rx_busy}, 32'd0);

        // 4: back-to-back, no idle
        send_byte(8'h00, 1'b1, BIT_CYC);
        send_byte(8'hFF, 1'b1, BIT_CYC);
        tick(10);
        check_eq("t4_done_cnt", done_cnt, 3);
        rx_byte = rx_q[1];
        check_eq("t4_first", {24'd0, rx_byte}, 32'h00);
        rx_byte = rx_q[2];
        check_eq("t4_second", {24'd0, rx_byte}, 32'hFF);

        // line low through reset release must not start a frame
        uart_rxd = 1'b0;
        tick(2);
        sys_rst_n = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        tick(30);
        check_eq("rl_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("rl_pulses", done_cnt + ferr_cnt, 4);
        uart_rxd = 1'b1;
        tick(10);

        // 5: reset during data bit 3 of 0x3C
        uart_rxd = 1'b0; tick(BIT_CYC);
        uart_rxd = 1'b0; tick(BIT_CYC);
        uart_rxd = 1'b0; tick(BIT_CYC);
        uart_rxd = 1'b1; tick(BIT_CYC);
        uart_rxd = 1'b1; tick(8);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_eq("t5_rst_data", {24'd0, uart_data}, 32'h00);
        check_eq("t5_rst_done", {31'd0, uart_done}, 32'd0);
        check_eq("t5_rst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("t5_rst_busy", {31'd0, rx_busy}, 32'd0);
        tick(3);
        sys_rst_n = 1'b1;
        tick(40);
        done_base = done_cnt;
        send_byte(8'h3C, 1'b1, BIT_CYC);
        tick(8);
        check_eq("t5_done_cnt", done_cnt - done_base, 1);
        check_eq("t5_data", {24'd0, uart_data}, 32'h3C);

        // 6: 17-cycle bits
        done_base = done_cnt;
        send_byte(8'h96, 1'b1, 17);
        tick(8);
        check_eq("t6_done_cnt", done_cnt - done_base, 1);
        check_eq("t6_data", {24'd0, uart_data}, 32'h96);
        check_eq("t6_ferr_cnt", ferr_cnt, 1);

        check_eq("done_ferr_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
